// File: rtl/line_edit_ctrl.sv
// ---------------------------------------------------------------------------
// line_edit_ctrl
//   Sequencing controller for the keyboard line-entry path. Takes PS/2 set-2
//   scan-code strobes, removes break (F0) and extended (E0) prefixes, decodes
//   Enter / BackSpace and drives the write port of an external line buffer.
//   A finished line is held behind a LINE_READY / LINE_ACK handshake.
//
//   Optional feature macro: EXT_CODE_FILTER_EN
//     defined   : a non-F0 byte after E0 is discarded (extended keys are mute)
//     undefined : E0 is only stripped; the next byte is handled like a plain
//                 byte (E0 5A completes the line, E0 75 writes 8'h75)
//
//   Ports
//     CLK, RESET           clock (rising edge), async active-high reset
//     SCAN_CODE/SCAN_VALID received byte and its one-cycle strobe
//     WR_EN/WR_ADDR/WR_DATA line buffer write strobe, address, make code
//     LINE_LEN             characters in the current line, 0..DEPTH
//     LINE_READY/LINE_ACK  line complete / consumer done
//     OVERFLOW             sticky: a character was lost in this line
//     DROP                 one-cycle pulse: a make code was discarded
// ---------------------------------------------------------------------------
module line_edit_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [7:0]    SCAN_CODE,
  input  logic          SCAN_VALID,
  output logic          WR_EN,
  output logic [AW-1:0] WR_ADDR,
  output logic [7:0]    WR_DATA,
  output logic [AW:0]   LINE_LEN,
  output logic          LINE_READY,
  input  logic          LINE_ACK,
  output logic          OVERFLOW,
  output logic          DROP
);

  localparam logic [7:0] P_SCAN_ENTER     = 8'h5A;
  localparam logic [7:0] P_SCAN_BACKSPACE = 8'h66;
  localparam logic [7:0] SC_BREAK         = 8'hF0;
  localparam logic [7:0] SC_EXT           = 8'hE0;
  localparam logic [AW:0] FULL            = (AW+1)'(DEPTH);

`ifdef EXT_CODE_FILTER_EN
  localparam bit EXT_FILTER = 1'b1;
`else
  localparam bit EXT_FILTER = 1'b0;
`endif

  typedef enum logic [2:0] {ACCEPT, BREAK, EXT, LOCKED, LOCKED_BRK} state_t;
  state_t state;

  // LINE_LEN is the character count register itself; it never wraps.
  logic acc_proc;   // byte gets full ACCEPT treatment this cycle
  logic lk_brk_n;   // locked side: a break prefix is pending after this cycle
  logic lk_drop;    // locked side: make code thrown away

  always_comb begin
    acc_proc = SCAN_VALID &&
               ((state == ACCEPT) ||
                (state == EXT && SCAN_CODE != SC_BREAK && !EXT_FILTER));
    // In LOCKED_BRK any byte consumes the pending break; in LOCKED an F0 arms it.
    lk_brk_n = (state == LOCKED_BRK) ? !SCAN_VALID
                                     : (SCAN_VALID && SCAN_CODE == SC_BREAK);
    lk_drop  = (state == LOCKED) && SCAN_VALID &&
               SCAN_CODE != SC_BREAK && SCAN_CODE != SC_EXT;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ACCEPT;
      WR_EN      <= 1'b0;
      WR_ADDR    <= '0;
      WR_DATA    <= '0;
      LINE_LEN   <= '0;
      LINE_READY <= 1'b0;
      OVERFLOW   <= 1'b0;
      DROP       <= 1'b0;
    end else begin
      WR_EN <= 1'b0;
      DROP  <= 1'b0;
      if (acc_proc) begin
        state <= ACCEPT;
        case (SCAN_CODE)
          SC_BREAK: state <= BREAK;
          SC_EXT:   state <= EXT;
          P_SCAN_ENTER: begin
            state      <= LOCKED;
            LINE_READY <= 1'b1;
          end
          P_SCAN_BACKSPACE: begin
            if (LINE_LEN != '0) LINE_LEN <= LINE_LEN - (AW+1)'(1);
          end
          default: begin
            if (LINE_LEN < FULL) begin
              WR_EN    <= 1'b1;
              WR_ADDR  <= LINE_LEN[AW-1:0];
              WR_DATA  <= SCAN_CODE;
              LINE_LEN <= LINE_LEN + (AW+1)'(1);
            end else begin
              OVERFLOW <= 1'b1;
              DROP     <= 1'b1;
            end
          end
        endcase
      end else begin
        case (state)
          BREAK: if (SCAN_VALID) state <= ACCEPT;
          EXT: begin
            // Only F0 or a filtered byte reaches here.
            if (SCAN_VALID) state <= (SCAN_CODE == SC_BREAK) ? BREAK : ACCEPT;
          end
          LOCKED, LOCKED_BRK: begin
            // The byte is judged under locked rules first; an ACK then unlocks
            // while keeping any break prefix that is still pending.
            DROP <= lk_drop;
            if (LINE_ACK) begin
              LINE_LEN   <= '0;
              LINE_READY <= 1'b0;
              OVERFLOW   <= 1'b0;
              state      <= lk_brk_n ? BREAK : ACCEPT;
            end else begin
              state      <= lk_brk_n ? LOCKED_BRK : LOCKED;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/line_edit_ctrl.md
# line_edit_ctrl

Sequencing controller for the keyboard line-entry path. Consumes PS/2 set-2 scan-code strobes, removes break and extended prefixes, decodes Enter and BackSpace, and manages the write pointer of an external line buffer RAM. It exposes a completed line through a ready/ack handshake and sits between the PS/2 receiver and the line consumer.

## Interface
- DEPTH, 32: line buffer entries, power of two, 2..256
- AW, 5: address width, log2(DEPTH)

- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- SCAN_CODE  in  8  scan code byte, qualified by SCAN_VALID
- SCAN_VALID  in  1  one-cycle strobe per received byte
- WR_EN  out  1  one-cycle line buffer write strobe
- WR_ADDR  out  AW  line buffer write address
- WR_DATA  out  8  line buffer write data (make code)
- LINE_LEN  out  AW+1  current character count, 0..DEPTH
- LINE_READY  out  1  line complete; held until LINE_ACK
- LINE_ACK  in  1  consumer has read the line; sampled only while LINE_READY=1
- OVERFLOW  out  1  sticky: a character was lost to a full buffer in this line
- DROP  out  1  one-cycle pulse: a make code was discarded

## Operation
- Constants come from the shared settings header: `P_SCAN_ENTER` (8'h5A) and `P_SCAN_BACKSPACE` (8'h66). Break prefix is 8'hF0; extended prefix is 8'hE0.
- FSM states: ACCEPT, BREAK, EXT, LOCKED, LOCKED_BRK. Reset state is ACCEPT.
- ACCEPT, per SCAN_VALID:
  - F0 -> BREAK.
  - E0 -> EXT.
  - Enter -> LINE_READY=1, -> LOCKED. No write.
  - BackSpace -> count-1 if count>0, otherwise no-op. No write. No RAM clear.
  - Any other code with count<DEPTH -> write code at address count, count+1.
  - Any other code with count==DEPTH -> no write, OVERFLOW=1, DROP pulse.
- BREAK: the next byte is discarded silently -> ACCEPT. A second F0 is also consumed.
- EXT: F0 -> BREAK. Any other byte is handled per Configuration.
- LOCKED:
  - F0 -> LOCKED_BRK.
  - E0 is ignored.
  - Any other byte is discarded with a DROP pulse.
- LOCKED_BRK: the next byte is discarded silently -> LOCKED.
- LINE_ACK while LINE_READY=1:
  - count=0, LINE_READY=0, OVERFLOW=0.
  - LOCKED -> ACCEPT; LOCKED_BRK -> BREAK.
- LINE_ACK while LINE_READY=0 is ignored.
- SCAN_VALID and LINE_ACK in the same cycle in LOCKED: the byte is evaluated under LOCKED rules (DROP if make), then the ACK transition applies.
  - Exception: F0 arriving with ACK goes to BREAK.
- count is AW+1 bits and never wraps. WR_ADDR = count[AW-1:0] at write time.

## Timing
- All outputs are registered.
- Reset values: WR_EN=0, WR_ADDR=0, WR_DATA=0, LINE_LEN=0, LINE_READY=0, OVERFLOW=0, DROP=0.
- Reset applies immediately and asynchronously. A reset mid-line discards the count and any pending line.
- Latency is 1 cycle from SCAN_VALID to WR_EN, DROP, LINE_READY or LINE_LEN update.
- LINE_LEN returns to 0 and LINE_READY falls 1 cycle after LINE_ACK.
- Back-to-back SCAN_VALID on consecutive cycles is supported at full rate.
- LINE_LEN is stable while LINE_READY=1.

## Configuration
- `EXT_CODE_FILTER_EN` defined:
  - In EXT, a non-F0 byte is discarded silently -> ACCEPT.
  - Extended keys (keypad Enter E0 5A, arrows) produce nothing.
- `EXT_CODE_FILTER_EN` undefined:
  - In EXT, a non-F0 byte is processed exactly as in ACCEPT.
  - The E0 prefix is stripped, so E0 5A completes the line and E0 75 writes 8'h75.

## Test plan
- Reset, then bytes 1C,F0,1C,32,F0,32,5A -> WR_EN pulses writing 1C@0 and 32@1; LINE_READY=1 with LINE_LEN=2; no DROP.
- Bytes 1C,66,66,33 -> count 1, then 0, then stays 0; 33 written @0; LINE_LEN=1.
- DEPTH=4, bytes 15,1D,24,2D,2C,5A -> 4 writes; 2C gives DROP and OVERFLOW=1; LINE_READY=1 with LINE_LEN=4; LINE_ACK clears OVERFLOW, LINE_READY and LINE_LEN.
- While LINE_READY=1, bytes F0,5A,1C -> F0 and 5A silent; 1C gives DROP; no WR_EN; LINE_LEN is unchanged.
- LINE_ACK coincident with F0 in LOCKED, then 1C, then 2A -> 1C is discarded (BREAK); 2A is written @0.
- E0,5A then F0,E0? No: E0,5A -> with `EXT_CODE_FILTER_EN` nothing happens; without it, LINE_READY=1 with LINE_LEN=0.
